// File: rtl/bram_read_arbiter.sv
// bram_read_arbiter: round-robin share of one BRAM read port between two requesters,
// with a bounded lock and a tag pipeline that routes read data back to its owner.
module bram_read_arbiter #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 12,
    parameter int RD_LAT     = 1,
    parameter int MAX_HOLD   = 6
) (
    input  logic                  clk_p,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic                  lock0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic                  lock1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic                  busy
);
    localparam logic [3:0] HMAX = 4'(MAX_HOLD);
    logic                  r_last, r_own_v, r_own_id, r_en;
    logic [3:0]            r_hold;
    logic [RD_LAT:0]       r_tv, r_tid;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_rd0, r_rd1;
    logic                  w_pick1, w_acc, w_lock, w_own_req;
    logic [3:0]            w_hold_nx;
    always_comb begin
        w_pick1   = (req0 && req1) ? ((r_own_v && r_hold < HMAX) ? r_own_id : ~r_last) : req1;
        gnt0      = !rst && req0 && !w_pick1;
        gnt1      = !rst && req1 && w_pick1;
        w_acc     = gnt0 || gnt1;
        w_lock    = gnt1 ? lock1 : lock0;
        w_own_req = r_own_id ? req1 : req0;
        w_hold_nx = (r_own_v && r_own_id == gnt1) ? ((r_hold == HMAX) ? HMAX : r_hold + 4'd1) : 4'd1;
    end
    // The last tag stage is the output stage; rdata is captured as a tag moves into it.
    always_ff @(posedge clk_p) begin
        if (rst) begin
            r_last   <= 1'b1;
            r_own_v  <= 1'b0;
            r_own_id <= 1'b0;
            r_hold   <= 4'd0;
            r_tv     <= '0;
            r_tid    <= '0;
            r_en     <= 1'b0;
            r_addr   <= '0;
            r_rd0    <= '0;
            r_rd1    <= '0;
        end else begin
            r_en  <= w_acc;
            r_tv  <= {r_tv[RD_LAT-1:0], w_acc};
            r_tid <= {r_tid[RD_LAT-1:0], gnt1};
            if (w_acc) begin
                r_addr   <= gnt1 ? addr1 : addr0;
                r_last   <= gnt1;
                r_own_v  <= w_lock;
                r_own_id <= gnt1;
                r_hold   <= w_lock ? w_hold_nx : 4'd0;
            end else if (r_own_v && !w_own_req) begin
                r_own_v <= 1'b0;
                r_hold  <= 4'd0;
            end
            if (r_tv[RD_LAT-1] && !r_tid[RD_LAT-1]) r_rd0 <= bram_dout;
            if (r_tv[RD_LAT-1] && r_tid[RD_LAT-1]) r_rd1 <= bram_dout;
        end
    end
    assign bram_en   = r_en;
    assign bram_addr = r_addr;
    assign rvalid0   = r_tv[RD_LAT] & ~r_tid[RD_LAT];
    assign rvalid1   = r_tv[RD_LAT] & r_tid[RD_LAT];
    assign rdata0    = r_rd0;
    assign rdata1    = r_rd1;
    assign busy      = r_en | (|r_tv);
endmodule

// File: tb/tb_bram_read_arbiter.sv
// tb_bram_read_arbiter: directed bench driving three arbiters (RD_LAT 1,2,3) from shared
// stimulus, each with its own BRAM model.
module tb_bram_read_arbiter;
    localparam int AW = 19, DW = 12;
    logic clk_p = 1'b0, rst = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic gnt0_a [3], gnt1_a [3], rvalid0_a [3], rvalid1_a [3], bram_en_a [3], busy_a [3];
    logic [DW-1:0] rdata0_a [3], rdata1_a [3], dout_a [3];
    logic [AW-1:0] bram_addr_a [3];
    int n_vec = 0, n_bad = 0;
    always #5 clk_p = ~clk_p;
    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return (a == 19'd400) ? 12'h0A5 : 12'(a * 5 + 7);
    endfunction
    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [DW-1:0] d1, d2;
        always_ff @(posedge clk_p) begin
            d1 <= mem_rd(bram_addr_a[g]);
            d2 <= d1;
        end
        assign dout_a[g] = (g == 0) ? mem_rd(bram_addr_a[g]) : (g == 1) ? d1 : d2;
        bram_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(g + 1), .MAX_HOLD(6)) u_dut (
            .clk_p(clk_p), .rst(rst),
            .req0(req0), .addr0(addr0), .lock0(lock0), .gnt0(gnt0_a[g]), .rvalid0(rvalid0_a[g]), .rdata0(rdata0_a[g]),
            .req1(req1), .addr1(addr1), .lock1(lock1), .gnt1(gnt1_a[g]), .rvalid1(rvalid1_a[g]), .rdata1(rdata1_a[g]),
            .bram_en(bram_en_a[g]), .bram_addr(bram_addr_a[g]), .bram_dout(dout_a[g]), .busy(busy_a[g])
        );
    end
    task automatic tick();
        @(posedge clk_p);
        #1;
    endtask
    task automatic test_reset();
        rst = 1'b1; req0 = 1'b1; addr0 = 19'd7;
        tick(); tick(); #2;
        for (int g = 0; g < 3; g++) begin
            n_vec++; if (gnt0_a[g] !== 1'b0) begin n_bad++; $display("FAIL reset_gnt0[%0d] got %b exp 0", g, gnt0_a[g]); end
            n_vec++; if (bram_en_a[g] !== 1'b0) begin n_bad++; $display("FAIL reset_bram_en[%0d] got %b exp 0", g, bram_en_a[g]); end
            n_vec++; if (busy_a[g] !== 1'b0) begin n_bad++; $display("FAIL reset_busy[%0d] got %b exp 0", g, busy_a[g]); end
            n_vec++; if (rvalid0_a[g] !== 1'b0 || rvalid1_a[g] !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid[%0d] got %b%b exp 00", g, rvalid0_a[g], rvalid1_a[g]); end
            n_vec++; if (bram_addr_a[g] !== '0) begin n_bad++; $display("FAIL reset_bram_addr[%0d] got %0d exp 0", g, bram_addr_a[g]); end
            n_vec++; if (rdata0_a[g] !== '0 || rdata1_a[g] !== '0) begin n_bad++; $display("FAIL reset_rdata[%0d] got %h/%h exp 0/0", g, rdata0_a[g], rdata1_a[g]); end
        end
        rst = 1'b0; req0 = 1'b0;
    endtask
    task automatic test_single();
        tick(); req0 = 1'b1; addr0 = 19'd400; #2;
        n_vec++; if (gnt0_a[0] !== 1'b1 || gnt1_a[0] !== 1'b0) begin n_bad++; $display("FAIL single_gnt got %b%b exp 10", gnt0_a[0], gnt1_a[0]); end
        tick(); req0 = 1'b0; #2;
        n_vec++; if (bram_en_a[0] !== 1'b1) begin n_bad++; $display("FAIL single_bram_en got %b exp 1", bram_en_a[0]); end
        n_vec++; if (bram_addr_a[0] !== 19'd400) begin n_bad++; $display("FAIL single_bram_addr got %0d exp 400", bram_addr_a[0]); end
        n_vec++; if (rvalid0_a[0] !== 1'b0) begin n_bad++; $display("FAIL single_early_rvalid0 got %b exp 0", rvalid0_a[0]); end
        tick(); #2;
        n_vec++; if (rvalid0_a[0] !== 1'b1) begin n_bad++; $display("FAIL single_rvalid0 got %b exp 1", rvalid0_a[0]); end
        n_vec++; if (rdata0_a[0] !== 12'h0A5) begin n_bad++; $display("FAIL single_rdata0 got %h exp 0a5", rdata0_a[0]); end
        n_vec++; if (rvalid1_a[0] !== 1'b0) begin n_bad++; $display("FAIL single_rvalid1 got %b exp 0", rvalid1_a[0]); end
        n_vec++; if (bram_en_a[0] !== 1'b0) begin n_bad++; $display("FAIL single_bram_en_off got %b exp 0", bram_en_a[0]); end
        tick(); #2;
        n_vec++; if (rvalid0_a[0] !== 1'b0) begin n_bad++; $display("FAIL single_rvalid0_pulse got %b exp 0", rvalid0_a[0]); end
    endtask
    task automatic test_alternate();
        logic exp_id;
        logic [DW-1:0] exp_d;
        int j;
        tick(); rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(); rst = 1'b0;
            req0 = (i < 6); req1 = (i < 6);
            addr0 = 19'(10 + (i + 1) / 2); addr1 = 19'(20 + i / 2);
            #2;
            if (i < 6) begin
                n_vec++; if (gnt0_a[0] !== (i % 2 == 0) || gnt1_a[0] !== (i % 2 == 1)) begin n_bad++; $display("FAIL alt_gnt cyc%0d got %b%b exp %b%b", i, gnt0_a[0], gnt1_a[0], i % 2 == 0, i % 2 == 1); end
            end
            if (i >= 2) begin
                j = i - 2;
                exp_id = (j % 2 == 1);
                exp_d = mem_rd(19'(exp_id ? 20 + j / 2 : 10 + j / 2));
                n_vec++; if (rvalid0_a[0] !== !exp_id || rvalid1_a[0] !== exp_id) begin n_bad++; $display("FAIL alt_rvalid cyc%0d got %b%b exp %b%b", i, rvalid0_a[0], rvalid1_a[0], !exp_id, exp_id); end
                n_vec++; if ((exp_id ? rdata1_a[0] : rdata0_a[0]) !== exp_d) begin n_bad++; $display("FAIL alt_rdata cyc%0d got %h exp %h", i, exp_id ? rdata1_a[0] : rdata0_a[0], exp_d); end
            end
        end
    endtask
    task automatic test_lock1();
        logic [AW-1:0] seq [6] = '{19'd399, 19'd801, 19'd0, 19'd800, 19'd1, 19'd799};
        tick(); req0 = 1'b1; addr0 = 19'd5; req1 = 1'b0; #2;
        n_vec++; if (gnt0_a[0] !== 1'b1) begin n_bad++; $display("FAIL lock1_pre_gnt0 got %b exp 1", gnt0_a[0]); end
        for (int i = 0; i < 9; i++) begin
            tick();
            req0 = (i <= 6); addr0 = 19'd50;
            req1 = (i <= 6); lock1 = (i <= 6); addr1 = (i < 6) ? seq[i] : 19'd2;
            #2;
            if (i <= 6) begin
                n_vec++; if (gnt0_a[0] !== (i == 6) || gnt1_a[0] !== (i < 6)) begin n_bad++; $display("FAIL lock1_gnt cyc%0d got %b%b exp %b%b", i, gnt0_a[0], gnt1_a[0], i == 6, i < 6); end
            end
            if (i >= 2 && i < 8) begin
                n_vec++; if (rvalid1_a[0] !== 1'b1 || rdata1_a[0] !== mem_rd(seq[i-2])) begin n_bad++; $display("FAIL lock1_ret cyc%0d got %b/%h exp 1/%h", i, rvalid1_a[0], rdata1_a[0], mem_rd(seq[i-2])); end
            end
            if (i == 8) begin
                n_vec++; if (rvalid0_a[0] !== 1'b1 || rdata0_a[0] !== mem_rd(19'd50)) begin n_bad++; $display("FAIL lock1_ret0 got %b/%h exp 1/%h", rvalid0_a[0], rdata0_a[0], mem_rd(19'd50)); end
            end
        end
        lock1 = 1'b0;
    endtask
    task automatic test_lock0_release();
        logic [4:0] pat [5] = '{5'b11000, 5'b11000, 5'b11100, 5'b00000, 5'b10100};
        logic [1:0] exp [5] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
        for (int i = 0; i < 5; i++) begin
            tick();
            {req0, lock0, req1} = pat[i][4:2];
            addr0 = 19'(60 + i); addr1 = 19'd70;
            #2;
            n_vec++; if ({gnt0_a[0], gnt1_a[0]} !== exp[i]) begin n_bad++; $display("FAIL lock0_gnt cyc%0d got %b%b exp %b", i, gnt0_a[0], gnt1_a[0], exp[i]); end
        end
        tick(); req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;
    endtask
    task automatic test_reset_inflight();
        tick(); req0 = 1'b1; addr0 = 19'd100; req1 = 1'b0; #2;
        n_vec++; if (gnt0_a[1] !== 1'b1) begin n_bad++; $display("FAIL rstfl_gnt0 got %b exp 1", gnt0_a[1]); end
        tick(); req0 = 1'b0; req1 = 1'b1; addr1 = 19'd200; #2;
        n_vec++; if (gnt1_a[1] !== 1'b1) begin n_bad++; $display("FAIL rstfl_gnt1 got %b exp 1", gnt1_a[1]); end
        tick(); req1 = 1'b0; rst = 1'b1; #2;
        n_vec++; if (busy_a[1] !== 1'b1 || rvalid0_a[1] !== 1'b0) begin n_bad++; $display("FAIL rstfl_pre busy/rvalid0 got %b/%b exp 1/0", busy_a[1], rvalid0_a[1]); end
        tick(); rst = 1'b0; #2;
        n_vec++; if ({gnt0_a[1], gnt1_a[1], rvalid0_a[1], rvalid1_a[1], bram_en_a[1], busy_a[1]} !== 6'b0) begin n_bad++; $display("FAIL rstfl_flags got %b%b%b%b%b%b exp 000000", gnt0_a[1], gnt1_a[1], rvalid0_a[1], rvalid1_a[1], bram_en_a[1], busy_a[1]); end
        n_vec++; if (bram_addr_a[1] !== '0 || rdata0_a[1] !== '0 || rdata1_a[1] !== '0) begin n_bad++; $display("FAIL rstfl_data got %0d/%h/%h exp 0/0/0", bram_addr_a[1], rdata0_a[1], rdata1_a[1]); end
        tick(); #2;
        n_vec++; if (rvalid0_a[1] !== 1'b0 || rvalid1_a[1] !== 1'b0 || busy_a[1] !== 1'b0) begin n_bad++; $display("FAIL rstfl_late got %b%b%b exp 000", rvalid0_a[1], rvalid1_a[1], busy_a[1]); end
    endtask
    task automatic test_back_to_back();
        logic exp_id;
        logic [AW-1:0] exp_a;
        for (int i = 0; i < 9; i++) begin
            tick();
            req0 = (i < 2); addr0 = 19'(300 + i);
            req1 = (i >= 2 && i < 4); addr1 = 19'(308 + i);
            #2;
            if (i < 4) begin
                n_vec++; if (gnt0_a[2] !== (i < 2) || gnt1_a[2] !== (i >= 2)) begin n_bad++; $display("FAIL b2b_gnt cyc%0d got %b%b exp %b%b", i, gnt0_a[2], gnt1_a[2], i < 2, i >= 2); end
                n_vec++; if (rvalid0_a[2] !== 1'b0 || rvalid1_a[2] !== 1'b0) begin n_bad++; $display("FAIL b2b_early_rvalid cyc%0d got %b%b exp 00", i, rvalid0_a[2], rvalid1_a[2]); end
            end else if (i < 8) begin
                exp_id = (i >= 6);
                exp_a = exp_id ? 19'(310 + i - 6) : 19'(300 + i - 4);
                n_vec++; if (rvalid0_a[2] !== !exp_id || rvalid1_a[2] !== exp_id) begin n_bad++; $display("FAIL b2b_rvalid cyc%0d got %b%b exp %b%b", i, rvalid0_a[2], rvalid1_a[2], !exp_id, exp_id); end
                n_vec++; if ((exp_id ? rdata1_a[2] : rdata0_a[2]) !== mem_rd(exp_a)) begin n_bad++; $display("FAIL b2b_rdata cyc%0d got %h exp %h", i, exp_id ? rdata1_a[2] : rdata0_a[2], mem_rd(exp_a)); end
            end else begin
                n_vec++; if (rvalid0_a[2] !== 1'b0 || rvalid1_a[2] !== 1'b0) begin n_bad++; $display("FAIL b2b_tail_rvalid got %b%b exp 00", rvalid0_a[2], rvalid1_a[2]); end
            end
            if (i == 7 || i == 8) begin
                n_vec++; if (busy_a[2] !== (i == 7)) begin n_bad++; $display("FAIL b2b_busy cyc%0d got %b exp %b", i, busy_a[2], i == 7); end
            end
        end
    endtask
    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_lock1();
        test_lock0_release();
        test_reset_inflight();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end
endmodule
